// File: rtl/cassette_player_if.sv
// ---------------------------------------------------------------------------
// cassette_player_if
// Purpose : SDRAM read-port bundle between the tape playback engine and the
//           SDRAM arbiter.
// Signals :
//   sdram_addr - byte address of the requested tape byte (player -> arbiter)
//   sdram_rd   - read request, held until acknowledged (player -> arbiter)
//   sdram_ack  - one-clk acknowledge, data valid in that cycle (arbiter -> player)
//   sdram_data - read data byte (arbiter -> player)
// Modports: master = playback engine, slave = SDRAM arbiter side.
// ---------------------------------------------------------------------------
interface cassette_player_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_rd;
  logic              sdram_ack;
  logic [7:0]        sdram_data;

  modport master (
    output sdram_addr,
    output sdram_rd,
    input  sdram_ack,
    input  sdram_data
  );

  modport slave (
    input  sdram_addr,
    input  sdram_rd,
    output sdram_ack,
    output sdram_data
  );
endinterface

// File: rtl/cassette_player.sv
// ---------------------------------------------------------------------------
// cassette_player
// Purpose : CoCo tape playback engine. Streams a tape image out of SDRAM one
//           byte at a time and turns it into the FSK cassette waveform
//           (1200 Hz cycle for a 0 bit, 2400 Hz cycle for a 1 bit, LSB first).
//           Handles motor gating, a silent gap after filename blocks and
//           end-of-tape detection by EOF block or by image length.
// Ports   :
//   clk, reset - system clock, synchronous active-high reset
//   Q          - CPU Q clock; each rising edge (seen in clk domain) is a tick
//   en         - global enable; ticks are ignored while low
//   play       - rising edge toggles between IDLE and running
//   rewind     - either edge rewinds to address 0 and goes IDLE
//   motor      - cassette motor relay; low pauses playback
//   tape_len   - image length in bytes, 0 = unlimited
//   sdram      - SDRAM read port (master modport of cassette_player_if)
//   data       - cassette waveform
//   active     - high whenever the engine is not IDLE or END
//   status     - current state encoding
// ---------------------------------------------------------------------------
module cassette_player #(
  parameter int ADDR_W    = 25,
  parameter int GAP_TICKS = 445000,
  parameter int HALF0     = 373,
  parameter int HALF1     = 186,
  parameter int CNT_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Q,
  input  logic              en,
  input  logic              play,
  input  logic              rewind,
  input  logic              motor,
  input  logic [ADDR_W-1:0] tape_len,
  cassette_player_if.master sdram,
  output logic              data,
  output logic              active,
  output logic [2:0]        status
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_BIT_HI = 3'd2,
    S_BIT_LO = 3'd3,
    S_CHECK  = 3'd4,
    S_GAP    = 3'd5,
    S_PAUSE  = 3'd6,
    S_END    = 3'd7
  } state_t;

  // Counters are loaded with length-1 and the transition happens at 0.
  localparam logic [CNT_W-1:0] HALF0_M1 = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] HALF1_M1 = CNT_W'(HALF1 - 1);
  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP_TICKS - 1);

  localparam logic [23:0] PAT_NAME = 24'h553C00;
  localparam logic [23:0] PAT_EOF1 = 24'h553CFF;
  localparam logic [23:0] PAT_EOF2 = 24'h00FF55;
  localparam logic [23:0] PAT_GAP  = 24'h555555;

  state_t            state_q;
  state_t            saved_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              data_q;
  logic [15:0]       seq_q;
  logic              name_q;
  logic [1:0]        eof_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        byte_q;
  logic [2:0]        bit_q;
  logic              q_prev_q;
  logic              play_prev_q;
  logic              rewind_prev_q;

  logic              tick;
  logic              step;
  logic              play_edge;
  logic              rewind_edge;
  logic [2:0]        bit_nxt;
  logic [23:0]       new_seq;
  logic [ADDR_W-1:0] addr_inc;
  logic              past_len;
  logic              hit_name;
  logic              hit_eof1;
  logic              hit_eof2;
  logic              hit_gap;
  logic [1:0]        eof_next;

  function automatic logic [CNT_W-1:0] half_m1(input logic b);
    half_m1 = b ? HALF1_M1 : HALF0_M1;
  endfunction

  // Tick qualification and control edges. Play/rewind history only advances
  // on enabled ticks, so an edge between ticks is picked up on the next one.
  assign tick        = Q & ~q_prev_q;
  assign step        = tick & en;
  assign play_edge   = step & play & ~play_prev_q;
  assign rewind_edge = step & (rewind ^ rewind_prev_q);

  // Block-pattern detection works on the sequence including the byte just
  // played, so the decision in CHECK sees the newest three bytes.
  assign bit_nxt  = bit_q + 3'd1;
  assign new_seq  = {seq_q, byte_q};
  assign addr_inc = addr_q + ADDR_W'(1);
  assign past_len = (tape_len != '0) && (addr_inc >= tape_len);
  assign hit_name = (new_seq == PAT_NAME);
  assign hit_eof1 = (new_seq == PAT_EOF1);
  assign hit_eof2 = (new_seq == PAT_EOF2) && (eof_q == 2'd1);
  assign hit_gap  = (new_seq == PAT_GAP) && name_q;
  assign eof_next = hit_eof2 ? 2'd2 : (hit_eof1 ? 2'd1 : eof_q);

  // Whole engine in one clocked process. Priority order: rewind, play, the
  // clk-rate FETCH acknowledge, then motor gating and tick-rate stepping.
  // The FETCH branch sits ahead of motor gating, which is what defers a
  // pause requested during FETCH until the byte has been delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      saved_q       <= S_IDLE;
      addr_q        <= '0;
      rd_q          <= 1'b0;
      data_q        <= 1'b0;
      seq_q         <= '0;
      name_q        <= 1'b0;
      eof_q         <= 2'd0;
      cnt_q         <= '0;
      byte_q        <= '0;
      bit_q         <= '0;
      q_prev_q      <= 1'b0;
      play_prev_q   <= 1'b0;
      rewind_prev_q <= 1'b0;
    end else begin
      q_prev_q <= Q;
      if (step) begin
        play_prev_q   <= play;
        rewind_prev_q <= rewind;
      end

      if (rewind_edge) begin
        addr_q  <= '0;
        seq_q   <= '0;
        name_q  <= 1'b0;
        eof_q   <= 2'd0;
        rd_q    <= 1'b0;
        data_q  <= 1'b0;
        state_q <= S_IDLE;
      end else if (play_edge) begin
        if (state_q == S_IDLE || state_q == S_END) begin
          seq_q   <= '0;
          name_q  <= 1'b0;
          eof_q   <= 2'd0;
          rd_q    <= 1'b1;
          state_q <= S_FETCH;
        end else begin
          rd_q    <= 1'b0;
          data_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      end else if (state_q == S_FETCH) begin
        if (sdram.sdram_ack) begin
          byte_q  <= sdram.sdram_data;
          rd_q    <= 1'b0;
          bit_q   <= 3'd0;
          cnt_q   <= half_m1(sdram.sdram_data[0]);
          data_q  <= 1'b1;
          state_q <= S_BIT_HI;
        end
      end else if (step) begin
        if (!motor && state_q != S_IDLE && state_q != S_END && state_q != S_PAUSE) begin
          saved_q <= state_q;
          state_q <= S_PAUSE;
        end else begin
          case (state_q)
            S_BIT_HI: begin
              if (cnt_q == '0) begin
                cnt_q   <= half_m1(byte_q[bit_q]);
                data_q  <= 1'b0;
                state_q <= S_BIT_LO;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
            S_BIT_LO: begin
              if (cnt_q == '0) begin
                if (bit_q == 3'd7) begin
                  state_q <= S_CHECK;
                end else begin
                  bit_q   <= bit_nxt;
                  cnt_q   <= half_m1(byte_q[bit_nxt]);
                  data_q  <= 1'b1;
                  state_q <= S_BIT_HI;
                end
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
            S_CHECK: begin
              seq_q <= new_seq[15:0];
              eof_q <= eof_next;
              if (hit_name) begin
                name_q <= 1'b1;
              end
              if (hit_gap) begin
                // Step back so the leader run replays after the gap; wraps
                // modulo 2^ADDR_W near address 0.
                name_q  <= 1'b0;
                addr_q  <= addr_q - ADDR_W'(2);
                cnt_q   <= GAP_M1;
                state_q <= S_GAP;
              end else begin
                addr_q <= addr_inc;
                if (eof_next == 2'd2 || past_len) begin
                  rd_q    <= 1'b0;
                  data_q  <= 1'b0;
                  state_q <= S_END;
                end else begin
                  rd_q    <= 1'b1;
                  state_q <= S_FETCH;
                end
              end
            end
            S_GAP: begin
              data_q <= 1'b0;
              if (cnt_q == '0) begin
                rd_q    <= 1'b1;
                state_q <= S_FETCH;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
            S_PAUSE: begin
              if (motor) begin
                state_q <= saved_q;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_rd   = rd_q;
  assign data             = data_q;
  assign status           = state_q;
  assign active           = (state_q != S_IDLE) && (state_q != S_END);

endmodule

// File: tb/tb_cassette_player.sv
// ---------------------------------------------------------------------------
// tb_cassette_player
// Purpose : self-checking bench for cassette_player with shortened timing
//           parameters. Q runs at clk/4 so one tick occurs every 4 clks; an
//           SDRAM model answers reads after a few clks unless held off.
// ---------------------------------------------------------------------------
module tb_cassette_player;

  localparam int ADDR_W    = 8;
  localparam int GAP_TICKS = 20;
  localparam int HALF0     = 6;
  localparam int HALF1     = 3;
  localparam int CNT_W     = 8;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              Q        = 1'b0;
  logic              en       = 1'b1;
  logic              play     = 1'b0;
  logic              rewind   = 1'b0;
  logic              motor    = 1'b1;
  logic [ADDR_W-1:0] tape_len = '0;
  logic              data;
  logic              active;
  logic [2:0]        status;

  logic       ack   = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] mem [256];
  bit         ackHold  = 1'b0;
  bit         forceAck = 1'b0;
  int         ackCount  = 0;
  int         tickCount = 0;
  int         errors    = 0;
  int         checks    = 0;
  int         expQ [$];

  cassette_player_if #(.ADDR_W(ADDR_W)) sdrIf ();

  assign sdrIf.sdram_ack  = ack;
  assign sdrIf.sdram_data = rdata;

  cassette_player #(
    .ADDR_W(ADDR_W),
    .GAP_TICKS(GAP_TICKS),
    .HALF0(HALF0),
    .HALF1(HALF1),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Q(Q),
    .en(en),
    .play(play),
    .rewind(rewind),
    .motor(motor),
    .tape_len(tape_len),
    .sdram(sdrIf),
    .data(data),
    .active(active),
    .status(status)
  );

  // 10-unit system clock.
  always #5 clk = ~clk;

  // Q toggles every 2 clks, giving one rising edge (tick) per 4 clks.
  initial begin
    forever begin
      repeat (2) @(negedge clk);
      Q = ~Q;
    end
  end

  // Reference tick counter, using the same edge rule the design uses.
  initial begin
    logic qPrev;
    qPrev = 1'b0;
    forever begin
      @(posedge clk);
      if (Q && !qPrev) tickCount++;
      qPrev = Q;
    end
  end

  // SDRAM model: acks a held request after 3 clks with mem[addr].
  initial begin
    int lat;
    lat = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (ack) begin
        ack = 1'b0;
      end else if (forceAck) begin
        ack      = 1'b1;
        rdata    = 8'hFF;
        forceAck = 1'b0;
      end else if (sdrIf.sdram_rd && !ackHold) begin
        lat++;
        if (lat >= 3) begin
          ack   = 1'b1;
          rdata = mem[sdrIf.sdram_addr];
          ackCount++;
          lat   = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic wait_status(input logic [2:0] v, input int maxClk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxClk; i++) begin
      @(negedge clk);
      if (status === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_data(input logic v, input int maxClk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxClk; i++) begin
      @(negedge clk);
      if (data === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_play();
    play = 1'b0;
    repeat (8) @(negedge clk);
    play = 1'b1;
  endtask

  task automatic do_rewind();
    rewind = ~rewind;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (status !== 3'd0) begin errors++; $display("[TB] FAIL reset_status: got %0d expected 0", status); end
    checks++; if (sdrIf.sdram_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 0", sdrIf.sdram_rd); end
    checks++; if (sdrIf.sdram_addr !== 8'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", sdrIf.sdram_addr); end
    checks++; if (data !== 1'b0) begin errors++; $display("[TB] FAIL reset_data: got %b expected 0", data); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_play_a5();
    bit         ok;
    int         drops;
    int         t0;
    int         len;
    int         expLen;
    logic       want;
    logic [7:0] v;
    v        = 8'hA5;
    mem[0]   = v;
    tape_len = '0;
    motor    = 1'b1;
    ackHold  = 1'b1;
    pulse_play();
    wait_status(3'd1, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL a5_fetch_entry: got status %0d expected 1", status); end
    drops = 0;
    repeat (20) begin
      @(negedge clk);
      if (sdrIf.sdram_rd !== 1'b1) drops++;
    end
    checks++; if (drops !== 0) begin errors++; $display("[TB] FAIL a5_rd_held: got %0d low samples expected 0", drops); end
    for (int i = 0; i < 8; i++) begin
      expLen = v[i] ? HALF1 : HALF0;
      expQ.push_back(expLen);
      expQ.push_back(expLen);
    end
    ackHold = 1'b0;
    wait_data(1'b1, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL a5_first_high: got data %b expected 1", data); end
    t0 = tickCount;
    for (int k = 0; k < 16; k++) begin
      want = (k % 2 == 1);
      if (k < 15) wait_data(want, 200, ok);
      else        wait_status(3'd4, 200, ok);
      len    = tickCount - t0;
      t0     = tickCount;
      expLen = expQ.pop_front();
      checks++; if (!ok || len !== expLen) begin errors++; $display("[TB] FAIL a5_half%0d: got %0d ticks (ok=%0d) expected %0d", k, len, ok, expLen); end
    end
    wait_status(3'd1, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL a5_next_fetch: got status %0d expected 1", status); end
    checks++; if (sdrIf.sdram_addr !== 8'd1) begin errors++; $display("[TB] FAIL a5_addr: got %0d expected 1", sdrIf.sdram_addr); end
  endtask

  task automatic load_gap_image();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h55; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hAA;
    mem[4] = 8'h55; mem[5] = 8'h55; mem[6] = 8'h55;
  endtask

  task automatic test_gap();
    bit ok;
    int t0;
    int len;
    int highs;
    load_gap_image();
    do_rewind();
    pulse_play();
    wait_status(3'd5, 6000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL gap_entry: got status %0d expected 5", status); end
    checks++; if (sdrIf.sdram_addr !== 8'd4) begin errors++; $display("[TB] FAIL gap_addr: got %0d expected 4", sdrIf.sdram_addr); end
    t0    = tickCount;
    highs = 0;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (data !== 1'b0) highs++;
      @(negedge clk);
      if (status !== 3'd5) begin
        ok = 1'b1;
        break;
      end
    end
    len = tickCount - t0;
    checks++; if (!ok || len !== GAP_TICKS) begin errors++; $display("[TB] FAIL gap_length: got %0d ticks (ok=%0d) expected %0d", len, ok, GAP_TICKS); end
    checks++; if (highs !== 0) begin errors++; $display("[TB] FAIL gap_silent: got %0d high samples expected 0", highs); end
    checks++; if (status !== 3'd1) begin errors++; $display("[TB] FAIL gap_resume_status: got %0d expected 1", status); end
    checks++; if (sdrIf.sdram_addr !== 8'd4) begin errors++; $display("[TB] FAIL gap_resume_addr: got %0d expected 4", sdrIf.sdram_addr); end
  endtask

  task automatic test_rewind_gap();
    bit ok;
    load_gap_image();
    do_rewind();
    pulse_play();
    wait_status(3'd5, 6000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rwgap_entry: got status %0d expected 5", status); end
    repeat (20) @(negedge clk);
    do_rewind();
    checks++; if (sdrIf.sdram_rd !== 1'b0) begin errors++; $display("[TB] FAIL rwgap_rd: got %b expected 0", sdrIf.sdram_rd); end
    checks++; if (sdrIf.sdram_addr !== 8'd0) begin errors++; $display("[TB] FAIL rwgap_addr: got %0d expected 0", sdrIf.sdram_addr); end
    checks++; if (status !== 3'd0) begin errors++; $display("[TB] FAIL rwgap_status: got %0d expected 0", status); end
    ackHold = 1'b1;
    pulse_play();
    wait_status(3'd1, 40, ok);
    checks++; if (!ok || sdrIf.sdram_addr !== 8'd0) begin errors++; $display("[TB] FAIL rwgap_replay_addr: got %0d (ok=%0d) expected 0", sdrIf.sdram_addr, ok); end
    ackHold = 1'b0;
  endtask

  task automatic test_eof();
    bit         ok;
    int         rdHigh;
    logic [2:0] prevS;
    foreach (mem[i]) mem[i] = 8'h11;
    mem[0] = 8'h55; mem[1] = 8'h3C; mem[2] = 8'hFF;
    mem[3] = 8'h00; mem[4] = 8'hFF; mem[5] = 8'h55;
    tape_len = '0;
    do_rewind();
    pulse_play();
    prevS = status;
    ok    = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (status === 3'd7) begin
        ok = 1'b1;
        break;
      end
      prevS = status;
    end
    checks++; if (!ok || prevS !== 3'd4) begin errors++; $display("[TB] FAIL eof_entry: got prev %0d now %0d expected 4 then 7", prevS, status); end
    checks++; if (sdrIf.sdram_addr !== 8'd6) begin errors++; $display("[TB] FAIL eof_addr: got %0d expected 6", sdrIf.sdram_addr); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL eof_active: got %b expected 0", active); end
    checks++; if (data !== 1'b0) begin errors++; $display("[TB] FAIL eof_data: got %b expected 0", data); end
    rdHigh = 0;
    repeat (200) begin
      @(negedge clk);
      if (sdrIf.sdram_rd !== 1'b0) rdHigh++;
    end
    checks++; if (rdHigh !== 0) begin errors++; $display("[TB] FAIL eof_no_read: got %0d rd samples expected 0", rdHigh); end
    checks++; if (status !== 3'd7) begin errors++; $display("[TB] FAIL eof_stays: got %0d expected 7", status); end
  endtask

  task automatic test_tape_len();
    bit         ok;
    logic [7:0] b;
    foreach (mem[i]) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h55) b = 8'h54;
      mem[i] = b;
    end
    tape_len = 8'd4;
    do_rewind();
    ackCount = 0;
    pulse_play();
    wait_status(3'd7, 8000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL len_end: got status %0d expected 7", status); end
    checks++; if (sdrIf.sdram_addr !== 8'd4) begin errors++; $display("[TB] FAIL len_addr: got %0d expected 4", sdrIf.sdram_addr); end
    checks++; if (ackCount !== 4) begin errors++; $display("[TB] FAIL len_reads: got %0d expected 4", ackCount); end
    checks++; if (sdrIf.sdram_rd !== 1'b0) begin errors++; $display("[TB] FAIL len_rd: got %b expected 0", sdrIf.sdram_rd); end
  endtask

  task automatic test_rewind_fetch();
    bit ok;
    ackHold = 1'b1;
    pulse_play();
    wait_status(3'd1, 40, ok);
    checks++; if (!ok || sdrIf.sdram_addr !== 8'd4) begin errors++; $display("[TB] FAIL rwf_restart_addr: got %0d (ok=%0d) expected 4", sdrIf.sdram_addr, ok); end
    repeat (12) @(negedge clk);
    checks++; if (sdrIf.sdram_rd !== 1'b1) begin errors++; $display("[TB] FAIL rwf_rd_pending: got %b expected 1", sdrIf.sdram_rd); end
    do_rewind();
    checks++; if (sdrIf.sdram_rd !== 1'b0) begin errors++; $display("[TB] FAIL rwf_rd: got %b expected 0", sdrIf.sdram_rd); end
    checks++; if (sdrIf.sdram_addr !== 8'd0) begin errors++; $display("[TB] FAIL rwf_addr: got %0d expected 0", sdrIf.sdram_addr); end
    checks++; if (status !== 3'd0) begin errors++; $display("[TB] FAIL rwf_status: got %0d expected 0", status); end
    pulse_play();
    wait_status(3'd1, 40, ok);
    checks++; if (!ok || sdrIf.sdram_addr !== 8'd0) begin errors++; $display("[TB] FAIL rwf_replay_addr: got %0d (ok=%0d) expected 0", sdrIf.sdram_addr, ok); end
    ackHold = 1'b0;
  endtask

  task automatic test_motor();
    bit ok;
    int r;
    int p;
    int s;
    int f;
    int consumed;
    foreach (mem[i]) mem[i] = 8'h00;
    tape_len = '0;
    do_rewind();
    ackHold = 1'b1;
    pulse_play();
    wait_status(3'd1, 40, ok);
    ackHold = 1'b0;
    wait_data(1'b1, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL motor_first_high: got data %b expected 1", data); end
    r = tickCount;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tickCount >= r + 2) break;
    end
    motor = 1'b0;
    wait_status(3'd6, 20, ok);
    p = tickCount;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL motor_pause: got status %0d expected 6", status); end
    checks++; if (data !== 1'b1) begin errors++; $display("[TB] FAIL motor_data_frozen: got %b expected 1", data); end
    repeat (40) @(negedge clk);
    checks++; if (data !== 1'b1 || status !== 3'd6) begin errors++; $display("[TB] FAIL motor_hold: got data %b status %0d expected 1 and 6", data, status); end
    motor = 1'b1;
    ok    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (status !== 3'd6) begin
        ok = 1'b1;
        break;
      end
    end
    s = tickCount;
    checks++; if (!ok || status !== 3'd2) begin errors++; $display("[TB] FAIL motor_resume: got status %0d expected 2", status); end
    wait_data(1'b0, 200, ok);
    f        = tickCount;
    consumed = p - r - 1;
    checks++; if (!ok || (f - s) !== (HALF0 - consumed)) begin errors++; $display("[TB] FAIL motor_remaining: got %0d ticks expected %0d", f - s, HALF0 - consumed); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ackHold = 1'b1;
    do_rewind();
    pulse_play();
    wait_status(3'd1, 40, ok);
    checks++; if (!ok || sdrIf.sdram_rd !== 1'b1) begin errors++; $display("[TB] FAIL mid_rd_before: got %b expected 1", sdrIf.sdram_rd); end
    play  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sdrIf.sdram_rd !== 1'b0) begin errors++; $display("[TB] FAIL mid_rd: got %b expected 0", sdrIf.sdram_rd); end
    checks++; if (status !== 3'd0) begin errors++; $display("[TB] FAIL mid_status: got %0d expected 0", status); end
    reset    = 1'b0;
    forceAck = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (status !== 3'd0 || data !== 1'b0) begin errors++; $display("[TB] FAIL mid_late_ack: got status %0d data %b expected 0 and 0", status, data); end
    ackHold = 1'b0;
  endtask

  initial begin
    $display("[TB] cassette_player bench start");
    test_reset();
    test_play_a5();
    test_gap();
    test_rewind_gap();
    test_eof();
    test_tape_len();
    test_rewind_fetch();
    test_motor();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
